// File: rtl/calc1.sv
// calc1: four independent 32-bit integer calculator ports (add, sub, shl, shr).
// Latency: fixed 3 cycles from command edge to response edge; response held one cycle.
// Backpressure: none; each port accepts at most one command every 2 cycles, and a cmd seen in OP2 is dropped.
//
// Ports:
//   c_clk               system clock, all state on rising edge
//   reset[7:0]          synchronous active-high reset, asserted when any bit is set
//   reqN_cmd_in[3:0]    command for port N (0 = no-op), N = 1..4
//   reqN_data_in[31:0]  operand1 in the command cycle, operand2 in the following cycle
//   out_respN[1:0]      0 none, 1 success, 2 overflow/underflow/invalid
//   out_dataN[31:0]     result, zero unless out_respN == 1
module calc1 (
   input  logic        c_clk,
   input  logic [7:0]  reset,
   input  logic [3:0]  req1_cmd_in,
   input  logic [31:0] req1_data_in,
   input  logic [3:0]  req2_cmd_in,
   input  logic [31:0] req2_data_in,
   input  logic [3:0]  req3_cmd_in,
   input  logic [31:0] req3_data_in,
   input  logic [3:0]  req4_cmd_in,
   input  logic [31:0] req4_data_in,
   output logic [1:0]  out_resp1,
   output logic [31:0] out_data1,
   output logic [1:0]  out_resp2,
   output logic [31:0] out_data2,
   output logic [1:0]  out_resp3,
   output logic [31:0] out_data3,
   output logic [1:0]  out_resp4,
   output logic [31:0] out_data4
);

   typedef enum logic [1:0] {IDLE, OP2, EXEC} state_t;

   localparam logic [1:0] RESP_NONE = 2'd0;
   localparam logic [1:0] RESP_OK   = 2'd1;
   localparam logic [1:0] RESP_ERR  = 2'd2;

   localparam logic [3:0] CMD_ADD = 4'd1;
   localparam logic [3:0] CMD_SUB = 4'd2;
   localparam logic [3:0] CMD_SHL = 4'd5;
   localparam logic [3:0] CMD_SHR = 4'd6;

   logic rst;
   assign rst = |reset;

   logic [3:0]  cmd_a  [4];
   logic [31:0] data_a [4];
   logic [1:0]  resp_a [4];
   logic [31:0] res_a  [4];

   assign cmd_a[0]  = req1_cmd_in;
   assign cmd_a[1]  = req2_cmd_in;
   assign cmd_a[2]  = req3_cmd_in;
   assign cmd_a[3]  = req4_cmd_in;
   assign data_a[0] = req1_data_in;
   assign data_a[1] = req2_data_in;
   assign data_a[2] = req3_data_in;
   assign data_a[3] = req4_data_in;

   for (genvar p = 0; p < 4; p++) begin : g_port
      state_t      state;
      logic [3:0]  cmd_q;
      logic [31:0] op1_q;
      logic [31:0] op2_q;
      // Result computed in EXEC waits one stage here so the output lands on edge N+3.
      logic        pend_vld;
      logic [1:0]  pend_resp;
      logic [31:0] pend_data;
      logic [1:0]  resp_q;
      logic [31:0] data_q;

      logic [32:0] sum;
      logic [1:0]  exe_resp;
      logic [31:0] exe_data;

      assign sum = {1'b0, op1_q} + {1'b0, op2_q};

      always_comb begin
         exe_resp = RESP_ERR;
         exe_data = '0;
         case (cmd_q)
            CMD_ADD: begin
               if (!sum[32]) begin
                  exe_resp = RESP_OK;
                  exe_data = sum[31:0];
               end
            end
            CMD_SUB: begin
               // operand1 is subtracted from operand2; a borrow is an error
               if (op1_q <= op2_q) begin
                  exe_resp = RESP_OK;
                  exe_data = op2_q - op1_q;
               end
            end
            CMD_SHL: begin
               exe_resp = RESP_OK;
               exe_data = op1_q << op2_q[4:0];
            end
            CMD_SHR: begin
               exe_resp = RESP_OK;
               exe_data = op1_q >> op2_q[4:0];
            end
            default: begin
               exe_resp = RESP_ERR;
               exe_data = '0;
            end
         endcase
      end

      always_ff @(posedge c_clk) begin
         if (rst) begin
            state     <= IDLE;
            cmd_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            pend_vld  <= 1'b0;
            pend_resp <= RESP_NONE;
            pend_data <= '0;
            resp_q    <= RESP_NONE;
            data_q    <= '0;
         end else begin
            resp_q   <= pend_vld ? pend_resp : RESP_NONE;
            data_q   <= pend_vld ? pend_data : '0;
            pend_vld <= 1'b0;
            case (state)
               IDLE: begin
                  if (cmd_a[p] != 4'd0) begin
                     cmd_q <= cmd_a[p];
                     op1_q <= data_a[p];
                     state <= OP2;
                  end
               end
               OP2: begin
                  op2_q <= data_a[p];
                  state <= EXEC;
               end
               EXEC: begin
                  pend_vld  <= 1'b1;
                  pend_resp <= exe_resp;
                  pend_data <= exe_data;
                  // A new command may be taken on the same edge the old one executes.
                  if (cmd_a[p] != 4'd0) begin
                     cmd_q <= cmd_a[p];
                     op1_q <= data_a[p];
                     state <= OP2;
                  end else begin
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end

      assign resp_a[p] = resp_q;
      assign res_a[p]  = data_q;
   end

   assign out_resp1 = resp_a[0];
   assign out_resp2 = resp_a[1];
   assign out_resp3 = resp_a[2];
   assign out_resp4 = resp_a[3];
   assign out_data1 = res_a[0];
   assign out_data2 = res_a[1];
   assign out_data3 = res_a[2];
   assign out_data4 = res_a[3];

endmodule

// File: tb/tb_calc1.sv
// tb_calc1: directed stimulus for calc1 with a scoreboard queue and an independent monitor.
// Expected responses carry their due cycle; the monitor checks code, data and arrival time.
// Outputs are sampled on the falling edge, inputs change right after the falling edge.
module tb_calc1;

   logic c_clk = 1'b0;
   always #5 c_clk = ~c_clk;

   logic [7:0]  reset;
   logic [3:0]  cmd  [4];
   logic [31:0] dat  [4];
   logic [1:0]  resp [4];
   logic [31:0] odat [4];

   calc1 dut (
      .c_clk        (c_clk),
      .reset        (reset),
      .req1_cmd_in  (cmd[0]),
      .req1_data_in (dat[0]),
      .req2_cmd_in  (cmd[1]),
      .req2_data_in (dat[1]),
      .req3_cmd_in  (cmd[2]),
      .req3_data_in (dat[2]),
      .req4_cmd_in  (cmd[3]),
      .req4_data_in (dat[3]),
      .out_resp1    (resp[0]),
      .out_data1    (odat[0]),
      .out_resp2    (resp[1]),
      .out_data2    (odat[1]),
      .out_resp3    (resp[2]),
      .out_data3    (odat[2]),
      .out_resp4    (resp[3]),
      .out_data4    (odat[3])
   );

   typedef struct {
      int          port;
      int          due;
      logic [1:0]  resp;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;
   bit   mon_en = 1'b0;

   always @(posedge c_clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(negedge c_clk);
   endtask

   // Drive the command cycle; the applying edge is cyc+1, the response edge cyc+4.
   task automatic issue(input int p, input logic [3:0] c, input logic [31:0] a,
                        input logic [1:0] er, input logic [31:0] ed, input bit expect_it);
      exp_t e;
      cmd[p] = c;
      dat[p] = a;
      if (expect_it) begin
         e.port = p;
         e.due  = cyc + 4;
         e.resp = er;
         e.data = ed;
         sb.push_back(e);
      end
   endtask

   task automatic operand2(input int p, input logic [31:0] b);
      cmd[p] = 4'd0;
      dat[p] = b;
   endtask

   // Monitor: pops the oldest expectation of the port whenever a response appears.
   always @(negedge c_clk) begin
      if (mon_en) begin
         for (int p = 0; p < 4; p++) begin
            int idx;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
               if (idx < 0 && sb[i].port == p) idx = i;
            if (resp[p] !== 2'd0) begin
               if (idx < 0) begin
                  chk(1'b0, $sformatf("unexpected_resp_p%0d", p + 1), {62'd0, resp[p]}, 64'd0);
               end else begin
                  chk(sb[idx].due == cyc, $sformatf("resp_cycle_p%0d", p + 1), cyc, sb[idx].due);
                  chk(resp[p] === sb[idx].resp, $sformatf("resp_code_p%0d", p + 1),
                      {62'd0, resp[p]}, {62'd0, sb[idx].resp});
                  chk(odat[p] === sb[idx].data, $sformatf("resp_data_p%0d", p + 1),
                      {32'd0, odat[p]}, {32'd0, sb[idx].data});
                  sb.delete(idx);
               end
            end else begin
               chk(odat[p] === 32'd0, $sformatf("idle_data_zero_p%0d", p + 1), {32'd0, odat[p]}, 64'd0);
               if (idx >= 0 && sb[idx].due <= cyc) begin
                  chk(1'b0, $sformatf("missing_resp_p%0d", p + 1), 64'd0, {62'd0, sb[idx].resp});
                  sb.delete(idx);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 8'h7F;
      for (int p = 0; p < 4; p++) begin
         cmd[p] = 4'd0;
         dat[p] = 32'd0;
      end
      // A command held during reset must never be captured.
      cmd[1] = 4'd1;
      dat[1] = 32'd1;
      repeat (7) begin
         tick();
         for (int p = 0; p < 4; p++) begin
            chk(resp[p] === 2'd0, $sformatf("reset_resp_p%0d", p + 1), {62'd0, resp[p]}, 64'd0);
            chk(odat[p] === 32'd0, $sformatf("reset_data_p%0d", p + 1), {32'd0, odat[p]}, 64'd0);
         end
      end
      reset  = 8'h00;
      cmd[1] = 4'd0;
      mon_en = 1'b1;
      repeat (4) tick();

      // Add on port 1, including carry out
      issue(0, 4'd1, 32'h0000_0005, 2'd1, 32'h0000_0008, 1'b1); tick();
      operand2(0, 32'h0000_0003);                               tick();
      issue(0, 4'd1, 32'hFFFF_FFFF, 2'd2, 32'h0, 1'b1);          tick();
      operand2(0, 32'h0000_0001);                               tick();

      // Subtract on port 2: normal, borrow, equal operands, then an invalid opcode
      issue(1, 4'd2, 32'd3, 2'd1, 32'd7, 1'b1);                 tick();
      operand2(1, 32'd10);                                      tick();
      issue(1, 4'd2, 32'd10, 2'd2, 32'd0, 1'b1);                tick();
      operand2(1, 32'd3);                                       tick();
      issue(1, 4'd2, 32'd5, 2'd1, 32'd0, 1'b1);                 tick();
      operand2(1, 32'd5);                                       tick();
      issue(1, 4'd15, 32'd9, 2'd2, 32'd0, 1'b1);                tick();
      operand2(1, 32'd4);                                       tick();

      // Shifts on port 3
      issue(2, 4'd5, 32'h0000_0001, 2'd1, 32'h8000_0000, 1'b1); tick();
      operand2(2, 32'd31);                                      tick();
      issue(2, 4'd6, 32'h8000_0000, 2'd1, 32'h0800_0000, 1'b1); tick();
      operand2(2, 32'h0000_0024);                               tick();

      // Port 4: shift amount of zero from op2 = 0x20, add without carry at the limit
      issue(3, 4'd5, 32'h0000_1234, 2'd1, 32'h0000_1234, 1'b1); tick();
      operand2(3, 32'h0000_0020);                               tick();
      issue(3, 4'd1, 32'hFFFF_FFFF, 2'd1, 32'hFFFF_FFFF, 1'b1); tick();
      operand2(3, 32'h0000_0000);                               tick();

      // All four ports at the same edge, port 4 invalid
      issue(0, 4'd1, 32'd100, 2'd1, 32'd123, 1'b1);
      issue(1, 4'd1, 32'h10, 2'd1, 32'h30, 1'b1);
      issue(2, 4'd1, 32'h7FFF_FFFF, 2'd1, 32'h8000_0000, 1'b1);
      issue(3, 4'd3, 32'd50, 2'd2, 32'd0, 1'b1);
      tick();
      operand2(0, 32'd23);
      operand2(1, 32'h20);
      operand2(2, 32'd1);
      operand2(3, 32'd60);
      tick();

      // Back-to-back on port 1; a cmd seen in OP2 is dropped
      issue(0, 4'd1, 32'd1, 2'd1, 32'd3, 1'b1);                 tick();
      cmd[0] = 4'd1; dat[0] = 32'd2;                            tick();
      issue(0, 4'd1, 32'hA, 2'd1, 32'h15, 1'b1);                tick();
      operand2(0, 32'hB);                                       tick();
      repeat (6) tick();

      // Reset during OP2 edge: command dropped
      issue(0, 4'd1, 32'd1, 2'd0, 32'd0, 1'b0);                 tick();
      operand2(0, 32'd2); reset = 8'h01;                        tick();
      reset = 8'h00;
      repeat (6) tick();

      // Reset on the EXEC edge: command dropped
      issue(0, 4'd1, 32'd4, 2'd0, 32'd0, 1'b0);                 tick();
      operand2(0, 32'd5);                                       tick();
      reset = 8'h80;                                            tick();
      reset = 8'h00;
      repeat (6) tick();

      // Reset on the response edge, then a command on the first edge out of reset
      issue(0, 4'd1, 32'd6, 2'd0, 32'd0, 1'b0);                 tick();
      operand2(0, 32'd7);                                       tick();
      tick();
      reset = 8'h7F;                                            tick();
      reset = 8'h00;
      issue(1, 4'd1, 32'd7, 2'd1, 32'd9, 1'b1);                 tick();
      operand2(1, 32'd2);                                       tick();
      repeat (6) tick();

      chk(sb.size() == 0, "scoreboard_empty", sb.size(), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/calc1.md
# calc1

Four-port 32-bit integer calculator. Each of four independent requester ports issues two-cycle commands: add, subtract, shift left, shift right. Each port returns a 2-bit response code and 32-bit result on its own output pair. The block sits between four requester agents and the system clock/reset domain; ports never interact.

## Interface
- No parameters. Data width is fixed at 32 bits, command width at 4 bits, and there are four ports.
- c_clk  in  1  system clock; all logic on rising edge.
- reset  in  8  one clock; reset is synchronous and active-high. The block is in reset on any edge where reset != 0 (reduction OR). The system drives 7'b1111111 for 7 cycles at power-up.
- reqN_cmd_in  in  4  command for port N (N = 1..4); 0 = no-op.
- reqN_data_in  in  32  operand1 in the command cycle; operand2 in the following cycle.
- out_respN  out  2  response for port N: 0 none, 1 success, 2 overflow/underflow/invalid command, 3 unused (never driven).
- out_dataN  out  32  result for port N; 0 whenever out_respN != 1.

## Operation
- Per-port state machine:
  - IDLE: a nonzero cmd_in at an edge captures cmd and operand1, then moves to OP2.
  - OP2: the next edge captures operand2, then moves to EXEC. cmd_in is ignored in OP2.
  - EXEC: the result is computed and registered. Returns to IDLE.
- Commands:
  - 1 add: result = op1 + op2, unsigned. If there is a carry out of bit 31, resp = 2 and data = 0.
  - 2 subtract: result = op2 − op1 (operand1 subtracted from operand2), unsigned. If op1 > op2 (borrow), resp = 2 and data = 0.
  - 5 shift left: result = op1 << op2[4:0], zero fill. op2[31:5] is ignored. Always resp = 1.
  - 6 shift right: result = op1 >> op2[4:0], logical, zero fill. Always resp = 1.
  - 3, 4, 7–15 (invalid): resp = 2, data = 0. These still consume the two-cycle command slot.
- Ports are fully independent, with no shared resources or arbitration. Simultaneous commands on all four ports complete in the same cycle.
- Each command produces exactly one response. Responses per port stay in issue order.

## Timing
- Command accepted at edge N (op1), op2 sampled at edge N+1.
- Response registered at edge N+3. out_respN/out_dataN are valid for exactly one clock period after edge N+3. Otherwise out_respN = 0 and out_dataN = 0.
- Fixed latency: 3 cycles from command edge to response edge, for every command including invalid ones.
- Back-to-back: the next command on the same port may be accepted at edge N+2 (earliest). Maximum throughput is one command per 2 cycles per port.
- A nonzero cmd_in while the port is in OP2 is not a command and is dropped.
- Reset:
  - At any edge with reset != 0, every port returns to IDLE and all in-flight commands are discarded without response.
  - All out_respN and out_dataN are 0 from the first reset edge on.
  - cmd_in is not captured at a reset edge.
  - The first command is accepted at the first edge with reset == 0.
- Reset mid-operation (during OP2 or EXEC) drops that command, and no response is issued afterwards.

## Test plan
- Reset hold: reset = 7'b1111111 for 7 cycles, then 0 → all out_resp/out_data = 0 during and after with no commands issued.
- Add on port 1: cmd 1, op1 = 0x0000_0005, op2 = 0x0000_0003 → at edge N+3, out_resp1 = 1 and out_data1 = 0x0000_0008. Also 0xFFFF_FFFF + 1 → resp 2, data 0.
- Subtract on port 2: cmd 2, op1 = 3, op2 = 10 → resp 1, data 7. Also op1 = 10, op2 = 3 → resp 2, data 0.
- Shifts on port 3: cmd 5, op1 = 0x0000_0001, op2 = 31 → 0x8000_0000, resp 1. cmd 6, op1 = 0x8000_0000, op2 = 0x0000_0024 (shift amount 4) → 0x0800_0000, resp 1.
- Invalid/concurrency: cmd 3 on port 4 while ports 1–3 issue valid adds at the same edge → port 4 resp 2, data 0; ports 1–3 resp 1 with correct sums, all at edge N+3.
- Back-to-back and reset mid-op: two adds on port 1 at edges N and N+2 → responses at N+3 and N+5. Asserting reset at N+1 instead → no response on port 1.
